pc_branch_unit: RTL and testbench

//  Parametrised program counter with conditional branches and a hardware return stack.

---
 rtl/pc_branch_unit_pkg.sv | 28 ++
 rtl/pc_branch_unit_return_stack.sv | 52 +++++
 rtl/pc_branch_unit.sv | 107 ++++++++++
 tb/tb_pc_branch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared types for the program counter / branch unit: op codes, FSM states
// and the branch-condition decode.
`timescale 1ns/1ps
package pc_branch_unit_pkg;

   typedef enum logic [2:0] {
      PC_NOP, PC_JMP, PC_JZ, PC_JNZ, PC_JN, PC_JC, PC_CALL, PC_RET
   } pc_op_t;

   typedef enum logic [1:0] {
      PC_RUN, PC_HALTED, PC_FAULT
   } pc_state_t;

   // True when a conditional jump should redirect; unconditional ops return 0.
   function automatic logic cond_met(pc_op_t op, logic z, logic n, logic c);
      logic met;
      met = 1'b0;
      case (op)
         PC_JZ:   met = z;
         PC_JNZ:  met = ~z;
         PC_JN:   met = n;
         PC_JC:   met = c;
         default: met = 1'b0;
      endcase
      return met;
   endfunction

endpackage

// File: rtl/pc_branch_unit_return_stack.sv
// LIFO of return addresses for CALL/RET. Only the occupancy counter is reset;
// entries above the level are never read.
`timescale 1ns/1ps
module return_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [LW-1:0]    level_q;
   logic [PW-1:0]    wr_idx;
   logic [PW-1:0]    rd_idx;

   assign full   = (level_q == LW'(DEPTH));
   assign empty  = (level_q == '0);
   assign level  = level_q;
   assign wr_idx = PW'(level_q);
   assign rd_idx = PW'(level_q - LW'(1));
   assign rdata  = empty ? '0 : mem_q[rd_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= '0;
      end else if (push && !full) begin
         level_q <= level_q + LW'(1);
      end else if (pop && !empty) begin
         level_q <= level_q - LW'(1);
      end
   end

   // NOTE: storage has no reset; clearing the level alone discards the contents
   // and keeps the array free of reset fan-out.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[wr_idx] <= wdata;
      end
   end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with conditional jumps, CALL/RET through a return stack,
// and a RUN/HALTED/FAULT state machine. All outputs are registered.
`timescale 1ns/1ps
module pc_branch_unit
   import pc_branch_unit_pkg::*;
#(
   parameter int                  ADDR_WIDTH   = 16,
   parameter int                  STACK_DEPTH  = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           pc_enable,
   input  logic                           op_valid,
   input  pc_op_t                         op,
   input  logic [ADDR_WIDTH-1:0]          target,
   input  logic                           flag_zero,
   input  logic                           flag_negative,
   input  logic                           flag_carry,
   input  logic                           halt,
   output logic [ADDR_WIDTH-1:0]          pc_out,
   output logic                           branch_taken,
   output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
   output logic                           halted,
   output logic                           fault
);

   pc_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  taken_q, taken_d;
   logic                  push, pop;
   logic [ADDR_WIDTH-1:0] ret_addr;
   logic                  stk_full, stk_empty;

   return_stack #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (pc_q),
      .rdata (ret_addr),
      .level (stack_level),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      taken_d = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         PC_RUN: begin
            if (halt) begin
               state_d = PC_HALTED;
            end else if (op_valid && (op == PC_JMP || cond_met(op, flag_zero, flag_negative, flag_carry))) begin
               pc_d    = target;
               taken_d = 1'b1;
            end else if (op_valid && op == PC_CALL) begin
               if (stk_full) begin
                  state_d = PC_FAULT;
               end else begin
                  push    = 1'b1;
                  pc_d    = target;
                  taken_d = 1'b1;
               end
            end else if (op_valid && op == PC_RET) begin
               if (stk_empty) begin
                  state_d = PC_FAULT;
               end else begin
                  pop     = 1'b1;
                  pc_d    = ret_addr;
                  taken_d = 1'b1;
               end
            end else if (pc_enable) begin
               pc_d = pc_q + ADDR_WIDTH'(1);
            end
         end
         PC_HALTED, PC_FAULT: ;
         default: state_d = PC_FAULT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= PC_RUN;
         pc_q    <= RESET_VECTOR;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         taken_q <= taken_d;
      end
   end

   assign pc_out       = pc_q;
   assign branch_taken = taken_q;
   assign halted       = (state_q == PC_HALTED);
   assign fault        = (state_q == PC_FAULT);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit (ADDR_WIDTH=8, STACK_DEPTH=2): directed
// scenarios plus random ops checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_pc_branch_unit;
   import pc_branch_unit_pkg::*;

   localparam int AW = 8;
   localparam int SD = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pc_enable, op_valid, flag_zero, flag_negative, flag_carry, halt;
   pc_op_t        op;
   logic [AW-1:0] target;
   logic [AW-1:0] pc_out;
   logic          branch_taken, halted, fault;
   logic [1:0]    stack_level;

   always #5 clk = ~clk;

   pc_branch_unit #(
      .ADDR_WIDTH   (AW),
      .STACK_DEPTH  (SD),
      .RESET_VECTOR (8'h00)
   ) dut (
      .clk           (clk),
      .reset         (rst_n),
      .pc_enable     (pc_enable),
      .op_valid      (op_valid),
      .op            (op),
      .target        (target),
      .flag_zero     (flag_zero),
      .flag_negative (flag_negative),
      .flag_carry    (flag_carry),
      .halt          (halt),
      .pc_out        (pc_out),
      .branch_taken  (branch_taken),
      .stack_level   (stack_level),
      .halted        (halted),
      .fault         (fault)
   );

   typedef struct {
      int pc;
      int taken;
      int level;
      int halted;
      int fault;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: architectural PC, stack as a queue, terminal flags.
   int   m_pc;
   int   m_stack[$];
   bit   m_halted, m_fault, m_taken;

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc     = 0;
      m_stack  = {};
      m_halted = 0;
      m_fault  = 0;
      m_taken  = 0;
   endtask

   task automatic model_edge(bit en, bit ov, pc_op_t o, int tgt, bit z, bit n, bit c, bit h);
      bit jump;
      jump    = 0;
      m_taken = 0;
      if (m_halted || m_fault) return;
      if (h) begin
         m_halted = 1;
         return;
      end
      if (ov) begin
         case (o)
            PC_JMP: jump = 1;
            PC_JZ:  jump = z;
            PC_JNZ: jump = !z;
            PC_JN:  jump = n;
            PC_JC:  jump = c;
            PC_CALL: begin
               if (m_stack.size() >= SD) begin
                  m_fault = 1;
                  return;
               end
               m_stack.push_back(m_pc);
               jump = 1;
            end
            PC_RET: begin
               if (m_stack.size() == 0) begin
                  m_fault = 1;
                  return;
               end
               m_pc    = m_stack.pop_back();
               m_taken = 1;
               return;
            end
            default: ;
         endcase
      end
      if (jump) begin
         m_pc    = tgt % 256;
         m_taken = 1;
      end else if (en) begin
         m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic drive_idle();
      pc_enable     = 0;
      op_valid      = 0;
      op            = PC_NOP;
      target        = '0;
      flag_zero     = 0;
      flag_negative = 0;
      flag_carry    = 0;
      halt          = 0;
   endtask

   task automatic step(bit en, bit ov, pc_op_t o, int tgt, bit z, bit n, bit c, bit h);
      exp_t e;
      @(negedge clk);
      pc_enable     = en;
      op_valid      = ov;
      op            = o;
      target        = AW'(tgt);
      flag_zero     = z;
      flag_negative = n;
      flag_carry    = c;
      halt          = h;
      model_edge(en, ov, o, tgt, z, n, c, h);
      e.pc     = m_pc;
      e.taken  = int'(m_taken);
      e.level  = m_stack.size();
      e.halted = int'(m_halted);
      e.fault  = int'(m_fault);
      sb_q.push_back(e);
   endtask

   // Asserted off-edge; outputs must clear without waiting for a clock.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 0;
      drive_idle();
      #1;
      check("rst_pc", int'(pc_out), 0);
      check("rst_taken", int'(branch_taken), 0);
      check("rst_level", int'(stack_level), 0);
      check("rst_halted", int'(halted), 0);
      check("rst_fault", int'(fault), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("pc_out", int'(pc_out), e.pc);
         check("branch_taken", int'(branch_taken), e.taken);
         check("stack_level", int'(stack_level), e.level);
         check("halted", int'(halted), e.halted);
         check("fault", int'(fault), e.fault);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      drive_idle();
      model_reset();

      // Increment and unconditional jump with a one-cycle taken pulse.
      do_reset();
      repeat (3) step(1, 0, PC_NOP, 0, 0, 0, 0, 0);
      step(0, 1, PC_JMP, 'h0A, 0, 0, 0, 0);
      step(0, 0, PC_NOP, 0, 0, 0, 0, 0);

      // Each condition taken, then not taken (falls back to increment).
      step(0, 1, PC_JZ,  'h20, 1, 0, 0, 0);
      step(1, 1, PC_JZ,  'h40, 0, 0, 0, 0);
      step(0, 1, PC_JNZ, 'h30, 0, 0, 0, 0);
      step(1, 1, PC_JNZ, 'h40, 1, 0, 0, 0);
      step(0, 1, PC_JN,  'h50, 0, 1, 0, 0);
      step(1, 1, PC_JN,  'h40, 1, 0, 1, 0);
      step(0, 1, PC_JC,  'h60, 0, 0, 1, 0);
      step(1, 1, PC_JC,  'h40, 1, 1, 0, 0);
      step(0, 1, PC_JC,  'h40, 0, 0, 0, 0);

      // Nested CALL/RET; redirect overrides pc_enable.
      step(0, 1, PC_JMP,  'h10, 0, 0, 0, 0);
      step(1, 1, PC_CALL, 'h30, 0, 0, 0, 0);
      step(0, 1, PC_JMP,  'h35, 0, 0, 0, 0);
      step(0, 1, PC_CALL, 'h50, 0, 0, 0, 0);
      step(1, 1, PC_RET,  0, 0, 0, 0, 0);
      step(1, 1, PC_RET,  0, 0, 0, 0, 0);
      step(1, 0, PC_NOP,  0, 0, 0, 0, 0);

      // Overflow fault is terminal.
      step(0, 1, PC_CALL, 'h20, 0, 0, 0, 0);
      step(0, 1, PC_CALL, 'h21, 0, 0, 0, 0);
      step(1, 1, PC_CALL, 'h60, 0, 0, 0, 0);
      step(1, 1, PC_JMP,  'h0A, 0, 0, 0, 0);
      step(1, 0, PC_NOP,  0, 0, 0, 0, 0);
      step(0, 1, PC_RET,  0, 0, 0, 0, 0);

      // Underflow fault.
      do_reset();
      step(1, 1, PC_RET, 0, 0, 0, 0, 0);
      step(1, 0, PC_NOP, 0, 0, 0, 0, 0);

      // Wrap at all-ones, halt beats a same-cycle jump, reset drops the stack.
      do_reset();
      step(0, 1, PC_JMP, 'hFF, 0, 0, 0, 0);
      step(1, 0, PC_NOP, 0, 0, 0, 0, 0);
      step(1, 1, PC_JMP, 'h0A, 0, 0, 0, 1);
      step(1, 1, PC_JMP, 'h0B, 0, 0, 0, 0);
      do_reset();
      step(1, 0, PC_NOP, 0, 0, 0, 0, 0);
      step(1, 1, PC_CALL, 'h44, 0, 0, 0, 0);
      step(1, 1, PC_CALL, 'h55, 0, 0, 0, 0);
      do_reset();
      step(1, 1, PC_RET, 0, 0, 0, 0, 0);

      // Random segments, each started from reset.
      for (int seg = 0; seg < 16; seg++) begin
         do_reset();
         for (int k = 0; k < 30; k++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 pc_op_t'(3'($urandom_range(0, 7))),
                 int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0));
         end
      end

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
